regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-ported register file with a per-register pending scoreboard.
//  - Serves NRD combinational reads and NWR writes per cycle, with optional write->read bypass.
//  - Tracks in-flight destinations: issue sets the pending bit, writeback clears it.
//  - Sits between the issue/decode stage and the writeback buses of the tensor-core datapath.
// PARAMETERS
//  DATA_W    32   register width in bits
//  NREGS     32   number of registers (power of 2, >=2); AW = $clog2(NREGS)
//  NRD       2    read ports
//  NWR       2    write ports
//  BYPASS    1    1: same-cycle write data forwarded to reads; 0: reads return stored value
//  ZERO_REG  1    1: register 0 hardwired to zero, writes/issues to it ignored
// PORTS
//  CLK        in   1            clock, rising edge
//  nRST       in   1            asynchronous active-low reset
//  wen        in   NWR          per-port write enable
//  wsel       in   NWR*AW       per-port write address (port i at [i*AW +: AW])
//  wdata      in   NWR*DATA_W   per-port write data
//  rsel       in   NRD*AW       per-port read address
//  rdata      out  NRD*DATA_W   per-port read data, combinational
//  rpend      out  NRD          pending bit of rsel[j] as seen by the reader
//  iss_valid  in   1            issue request: reserve destination iss_rd
//  iss_rd     in   AW           destination register to reserve
//  iss_ready  out  1            issue may be accepted this cycle
//  flush      in   1            synchronous clear of all pending bits and of werr
//  pend_vec   out  NREGS        registered pending scoreboard
//  werr       out  1            sticky: two write ports hit the same register in one cycle
// BEHAVIOUR
//  - Clock and reset: one clock, CLK. nRST low asynchronously clears all registers,
//    pend_vec and werr to 0.
//  - Write enable: port i writes iff wen[i] && !(ZERO_REG && wsel_i==0).
//  - Write timing: wdata_i is stored at the next rising edge.
//  - Same-address writes: highest port index wins. werr sets on the same edge and holds until flush.
//  - Reads:
//    - rdata_j = reg[rsel_j], zero-latency.
//    - ZERO_REG && rsel_j==0 -> rdata_j=0 and rpend_j=0.
//    - BYPASS=1 and a write port targets rsel_j this cycle -> rdata_j is that port's wdata
//      (highest index wins), and rpend_j=0.
//    - Otherwise rpend_j = pend_vec[rsel_j].
//  - Issue handshake:
//    - iss_ready = !flush && !pend_vec[iss_rd]. Waiting on a write-after-write stalls the issue;
//      no accept while the destination is already pending.
//    - Accepted when iss_valid && iss_ready. Sets pend_vec[iss_rd] at the next edge, except for
//      register 0 when ZERO_REG=1: accepted, no bit set.
//    - iss_ready does not depend on iss_valid.
//  - Scoreboard update, each edge:
//    - pend_next = flush ? 0 : (pend_vec & ~wclr_mask) | iss_set_mask.
//    - wclr_mask = bits of all enabled write addresses.
//    - Set wins over clear on the same register in the same cycle.
//    - A write to a non-pending register is legal and leaves its pend bit 0.
//  - Flush:
//    - Clears pend_vec and werr only; register contents are kept.
//    - Writes in the same cycle still update data.
//    - An issue in the same cycle is refused (iss_ready=0).
//  - Out-of-range addresses cannot occur (NREGS is a power of 2).
//  - nRST mid-operation: everything returns to reset values immediately; no partial write survives.
// TESTING
//  1. Reset then read all regs on every port -> rdata=0, rpend=0, pend_vec=0, werr=0, iss_ready=1.
//  2. wen=01, wsel0=5, wdata0=0xDEADBEEF; same cycle rsel0=5:
//     - BYPASS=1 -> rdata0=0xDEADBEEF in that cycle.
//     - BYPASS=0 -> old 0, then 0xDEADBEEF the next cycle.
//  3. Zero register: write 0x1234 to r0, and issue r0 -> rdata(r0)=0, pend_vec[0]=0.
//  4. Issue r7 -> pend_vec[7]=1 next cycle, iss_ready=0 for iss_rd=7. Write r7 via port 1
//     -> pend_vec[7]=0 next cycle. Then issue r7 together with a write to r7 -> pend_vec[7]=1 (set wins).
//  5. Both write ports to r3, data 0xA / 0xB -> r3=0xB, werr=1 sticky. Then flush -> werr=0,
//     pend_vec=0, r3 still 0xB.
//  6. Issue r9, drop nRST mid-cycle -> pend_vec=0 and r9=0 immediately, no edge needed.
//     Randomised multi-port traffic is checked against a reference model.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register pending scoreboard.
// Reads are combinational with optional same-cycle write forwarding; issue/writeback drive the scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*AW-1:0]     wsel,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD*AW-1:0]     rsel,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rpend,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic                  iss_ready,
  input  logic                  flush,
  output logic [NREGS-1:0]      pend_vec,
  output logic                  werr
);

  logic [AW-1:0]     wsel_a  [NWR];
  logic [DATA_W-1:0] wdata_a [NWR];
  logic [AW-1:0]     rsel_a  [NRD];
  logic [NWR-1:0]    wr_eff;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_next;
  logic [NREGS-1:0]  wclr_mask;
  logic [NREGS-1:0]  iss_set_mask;
  logic              werr_q;
  logic              wr_coll;
  logic              iss_acc;

  for (genvar wi = 0; wi < NWR; wi++) begin : g_wport
    assign wsel_a[wi]  = wsel[wi*AW +: AW];
    assign wdata_a[wi] = wdata[wi*DATA_W +: DATA_W];
    assign wr_eff[wi]  = wen[wi] && !((ZERO_REG != 0) && (wsel_a[wi] == '0));
  end

  for (genvar ri = 0; ri < NRD; ri++) begin : g_rport
    assign rsel_a[ri] = rsel[ri*AW +: AW];
  end

  // Any pair of effective writes landing on the same register flags an error.
  always_comb begin
    wr_coll = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int k = i + 1; k < NWR; k++) begin
        if (wr_eff[i] && wr_eff[k] && (wsel_a[i] == wsel_a[k])) wr_coll = 1'b1;
      end
    end
  end

  always_comb begin
    wclr_mask = '0;
    for (int i = 0; i < NWR; i++) begin
      if (wr_eff[i]) wclr_mask[wsel_a[i]] = 1'b1;
    end
  end

  assign iss_ready = !flush && !pend_q[iss_rd];
  assign iss_acc   = iss_valid && iss_ready;

  always_comb begin
    iss_set_mask = '0;
    if (iss_acc && !((ZERO_REG != 0) && (iss_rd == '0))) iss_set_mask[iss_rd] = 1'b1;
  end

  // Set is OR'd after the clear so a same-cycle reissue keeps the bit.
  assign pend_next = flush ? '0 : ((pend_q & ~wclr_mask) | iss_set_mask);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pend_q <= '0;
      werr_q <= 1'b0;
    end else begin
      pend_q <= pend_next;
      werr_q <= flush ? 1'b0 : (werr_q | wr_coll);
    end
  end

  // Ascending port order: the last non-blocking assignment (highest port) wins.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_eff[i]) regs[wsel_a[i]] <= wdata_a[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    rpend = '0;
    for (int j = 0; j < NRD; j++) begin
      rdata[j*DATA_W +: DATA_W] = regs[rsel_a[j]];
      rpend[j]                  = pend_q[rsel_a[j]];
      if (BYPASS != 0) begin
        for (int i = 0; i < NWR; i++) begin
          if (wr_eff[i] && (wsel_a[i] == rsel_a[j])) begin
            rdata[j*DATA_W +: DATA_W] = wdata_a[i];
            rpend[j]                  = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (rsel_a[j] == '0)) begin
        rdata[j*DATA_W +: DATA_W] = '0;
        rpend[j]                  = 1'b0;
      end
    end
  end

  assign pend_vec = pend_q;
  assign werr     = werr_q;

endmodule
